// File: rtl/ioexp_fb_monitor.sv
// Debounce and command supervision of the MAX7317 P8/P9 feedback pair.
// Per channel: debouncer, saturating transition counter, OK/SETTLE supervisor, sticky fault.
module ioexp_fb_monitor #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd4915,
  parameter logic [19:0] TIMEOUT_CYCLES  = 20'd983040,
  parameter logic [15:0] REG_ADDR        = 16'h00A0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioexp_cfg_present,
  input  logic [1:0]  P98,
  input  logic        mv_en,
  input  logic        safety_en,
  input  logic [15:0] reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_wen,
  output logic [31:0] reg_rdata,
  output logic        mv_good,
  output logic        safety_good,
  output logic        fb_fault
);

  typedef enum logic {StOk, StSettle} state_e;

  // Index 1 is the mv channel, index 0 the safety channel.
  logic [1:0]  cmd;
  logic [1:0]  cmd_edge;
  logic [1:0]  stable_q, stable_d;
  logic [15:0] cnt_q   [2];
  logic [15:0] cnt_d   [2];
  logic [7:0]  trans_q [2];
  logic [7:0]  trans_d [2];
  logic [19:0] timer_q [2];
  state_e      state_q [2];
  logic [1:0]  cmd_prev_q;
  logic [1:0]  sticky_q, sticky_d;
  logic [1:0]  fault_set;
  logic        reg_hit;
  logic        clr_sticky;
  logic        clr_trans;
  logic        unused_wdata;

  assign cmd          = {mv_en, safety_en};
  assign cmd_edge     = cmd ^ cmd_prev_q;
  assign reg_hit      = reg_wen && (reg_waddr == REG_ADDR);
  assign clr_sticky   = reg_hit && reg_wdata[31];
  assign clr_trans    = reg_hit && reg_wdata[30];
  assign unused_wdata = ^reg_wdata[29:0];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      if (!ioexp_cfg_present) begin
        stable_d[i] = 1'b0;
        cnt_d[i]    = '0;
      end else if (P98[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
        stable_d[i] = P98[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end

      trans_d[i] = trans_q[i];
      if (clr_trans) begin
        trans_d[i] = '0;
      end else if ((stable_d[i] != stable_q[i]) && (trans_q[i] != 8'hFF)) begin
        trans_d[i] = trans_q[i] + 8'd1;
      end

      fault_set[i] = 1'b0;
      if (ioexp_cfg_present && !cmd_edge[i] && (stable_q[i] != cmd[i])) begin
        fault_set[i] = (state_q[i] == StOk) || (timer_q[i] == TIMEOUT_CYCLES - 20'd1);
      end
    end
    // A fault set in the same cycle as a clear wins.
    sticky_d = fault_set | (sticky_q & ~{2{clr_sticky}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q   <= '0;
      cmd_prev_q <= '0;
      sticky_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= '0;
        trans_q[i] <= '0;
        timer_q[i] <= '0;
        state_q[i] <= StOk;
      end
    end else begin
      stable_q   <= stable_d;
      cmd_prev_q <= cmd;
      sticky_q   <= sticky_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= cnt_d[i];
        trans_q[i] <= trans_d[i];
        if (!ioexp_cfg_present) begin
          state_q[i] <= StOk;
          timer_q[i] <= '0;
        end else begin
          unique case (state_q[i])
            StOk: begin
              if (cmd_edge[i]) begin
                state_q[i] <= StSettle;
                timer_q[i] <= '0;
              end
            end
            StSettle: begin
              if (stable_q[i] == cmd[i]) begin
                state_q[i] <= StOk;
              end else if (cmd_edge[i]) begin
                timer_q[i] <= '0;
              end else if (timer_q[i] == TIMEOUT_CYCLES - 20'd1) begin
                state_q[i] <= StOk;
              end else begin
                timer_q[i] <= timer_q[i] + 20'd1;
              end
            end
            default: state_q[i] <= StOk;
          endcase
        end
      end
    end
  end

  assign mv_good     = stable_q[1];
  assign safety_good = stable_q[0];
  assign fb_fault    = |sticky_q;

  assign reg_rdata = {fb_fault, sticky_q[1], sticky_q[0],
                      state_q[1] == StSettle, state_q[0] == StSettle,
                      ioexp_cfg_present, P98, stable_q, mv_en, safety_en,
                      4'b0000, trans_q[1], trans_q[0]};

endmodule

// File: tb/tb_ioexp_fb_monitor.sv
// Directed bench for ioexp_fb_monitor with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_ioexp_fb_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioexp_cfg_present;
  logic [1:0]  P98;
  logic        mv_en;
  logic        safety_en;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen;
  logic [31:0] reg_rdata;
  logic        mv_good;
  logic        safety_good;
  logic        fb_fault;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] Addr = 16'h00A0;

  ioexp_fb_monitor #(
    .DEBOUNCE_CYCLES(16'd4),
    .TIMEOUT_CYCLES (20'd20),
    .REG_ADDR       (Addr)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ioexp_cfg_present(ioexp_cfg_present),
    .P98              (P98),
    .mv_en            (mv_en),
    .safety_en        (safety_en),
    .reg_waddr        (reg_waddr),
    .reg_wdata        (reg_wdata),
    .reg_wen          (reg_wen),
    .reg_rdata        (reg_rdata),
    .mv_good          (mv_good),
    .safety_good      (safety_good),
    .fb_fault         (fb_fault)
  );

  always #5 clk = ~clk;

  // Advance n cycles; returns 1 ns into the new cycle.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle register write; returns in the cycle after the write.
  task automatic reg_write(input logic [15:0] a, input logic [31:0] d);
    reg_waddr = a;
    reg_wdata = d;
    reg_wen   = 1'b1;
    tick(1);
    reg_wen   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ioexp_cfg_present = 1'b1;
    P98 = 2'b00;
    mv_en = 1'b0;
    safety_en = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    reg_wen = 1'b0;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (reg_rdata !== 32'h0400_0000) begin
      errors++; $display("FAIL reset_rdata: got %h want %h", reg_rdata, 32'h0400_0000);
    end
    checks++;
    if ({mv_good, safety_good, fb_fault} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: got %b want 000", {mv_good, safety_good, fb_fault});
    end
  endtask

  task automatic test_glitch;
    tick(1);
    P98[1] = 1'b1;
    tick(3);
    P98[1] = 1'b0;
    tick(6);
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b0 || reg_rdata[15:8] !== 8'd0) begin
      errors++; $display("FAIL glitch_reject: mv_good=%b cnt=%0d want 0/0", mv_good, reg_rdata[15:8]);
    end
    tick(1);
    P98[1] = 1'b1;
    tick(3);
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b0) begin
      errors++; $display("FAIL glitch_early: mv_good=%b want 0", mv_good);
    end
    tick(1);
    P98[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b1 || reg_rdata[15:8] !== 8'd1) begin
      errors++; $display("FAIL glitch_accept: mv_good=%b cnt=%0d want 1/1", mv_good, reg_rdata[15:8]);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if (reg_rdata[30] !== 1'b1) begin
      errors++; $display("FAIL glitch_ok_mismatch: sticky_mv=%b want 1", reg_rdata[30]);
    end
    tick(5);
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b0 || reg_rdata[15:8] !== 8'd2) begin
      errors++; $display("FAIL glitch_fall: mv_good=%b cnt=%0d want 0/2", mv_good, reg_rdata[15:8]);
    end
    reg_write(Addr, 32'h8000_0000);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b0) begin
      errors++; $display("FAIL glitch_clear: fb_fault=%b want 0", fb_fault);
    end
  endtask

  task automatic test_good_settle;
    tick(1);
    mv_en = 1'b1;
    tick(1);
    @(negedge clk);
    checks++;
    if (reg_rdata[28] !== 1'b1) begin
      errors++; $display("FAIL settle_enter: ch1_settle=%b want 1", reg_rdata[28]);
    end
    tick(4);
    P98[1] = 1'b1;
    tick(3);
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b0) begin
      errors++; $display("FAIL settle_c8: mv_good=%b want 0", mv_good);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b1) begin
      errors++; $display("FAIL settle_c9: mv_good=%b want 1", mv_good);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if (reg_rdata[28] !== 1'b0 || reg_rdata[31] !== 1'b0) begin
      errors++; $display("FAIL settle_done: settle=%b fault=%b want 0/0", reg_rdata[28], reg_rdata[31]);
    end
  endtask

  task automatic test_timeout;
    tick(1);
    safety_en = 1'b1;
    tick(20);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b0 || reg_rdata[27] !== 1'b1) begin
      errors++; $display("FAIL timeout_c20: fault=%b settle=%b want 0/1", fb_fault, reg_rdata[27]);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b1 || reg_rdata[29] !== 1'b1 || reg_rdata[27] !== 1'b0) begin
      errors++; $display("FAIL timeout_c21: fault=%b sticky=%b settle=%b want 1/1/0",
                         fb_fault, reg_rdata[29], reg_rdata[27]);
    end
    tick(1);
    safety_en = 1'b0;
    tick(3);
    reg_write(Addr, 32'h8000_0000);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b0) begin
      errors++; $display("FAIL timeout_clear1: fb_fault=%b want 0", fb_fault);
    end
    // Second run: command re-asserted at cycle 10 restarts the settle window.
    tick(1);
    safety_en = 1'b1;
    tick(9);
    safety_en = 1'b0;
    tick(1);
    safety_en = 1'b1;
    tick(11);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b0) begin
      errors++; $display("FAIL timeout2_c21: fb_fault=%b want 0", fb_fault);
    end
    tick(9);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b0) begin
      errors++; $display("FAIL timeout2_c30: fb_fault=%b want 0", fb_fault);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b1 || reg_rdata[29] !== 1'b1) begin
      errors++; $display("FAIL timeout2_c31: fault=%b sticky=%b want 1/1", fb_fault, reg_rdata[29]);
    end
    P98[0] = 1'b1;
    tick(6);
    reg_write(Addr, 32'h8000_0000);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b0 || safety_good !== 1'b1) begin
      errors++; $display("FAIL timeout_clear2: fault=%b safety_good=%b want 0/1", fb_fault, safety_good);
    end
  endtask

  task automatic test_unexpected_drop;
    tick(1);
    P98[1] = 1'b0;
    tick(3);
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b1 || reg_rdata[30] !== 1'b0) begin
      errors++; $display("FAIL drop_c3: mv_good=%b sticky=%b want 1/0", mv_good, reg_rdata[30]);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b0 || reg_rdata[30] !== 1'b0) begin
      errors++; $display("FAIL drop_c4: mv_good=%b sticky=%b want 0/0", mv_good, reg_rdata[30]);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if (reg_rdata[30] !== 1'b1 || fb_fault !== 1'b1) begin
      errors++; $display("FAIL drop_c5: sticky=%b fault=%b want 1/1", reg_rdata[30], fb_fault);
    end
    tick(1);
    P98[1] = 1'b1;
    tick(5);
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b1) begin
      errors++; $display("FAIL drop_recover: mv_good=%b want 1", mv_good);
    end
  endtask

  task automatic test_clear;
    tick(1);
    P98[1] = 1'b0;
    tick(6);
    reg_write(Addr, 32'h8000_0000);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b1 || reg_rdata[30] !== 1'b1) begin
      errors++; $display("FAIL clear_set_wins: fault=%b sticky=%b want 1/1", fb_fault, reg_rdata[30]);
    end
    P98[1] = 1'b1;
    tick(6);
    reg_write(16'h00A4, 32'hC000_0000);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b1 || reg_rdata[15:0] !== 16'h0701) begin
      errors++; $display("FAIL clear_other_addr: fault=%b cnts=%h want 1/0701", fb_fault, reg_rdata[15:0]);
    end
    reg_write(Addr, 32'h8000_0000);
    @(negedge clk);
    checks++;
    if (fb_fault !== 1'b0 || reg_rdata[30:29] !== 2'b00) begin
      errors++; $display("FAIL clear_sticky: fault=%b sticky=%b want 0/00", fb_fault, reg_rdata[30:29]);
    end
    reg_write(Addr, 32'h4000_0000);
    @(negedge clk);
    checks++;
    if (reg_rdata[15:0] !== 16'h0000) begin
      errors++; $display("FAIL clear_counters: cnts=%h want 0000", reg_rdata[15:0]);
    end
  endtask

  task automatic test_not_present;
    tick(1);
    P98[0] = 1'b0;
    tick(6);
    @(negedge clk);
    checks++;
    if (reg_rdata[29] !== 1'b1 || safety_good !== 1'b0) begin
      errors++; $display("FAIL np_pre_fault: sticky=%b safety_good=%b want 1/0", reg_rdata[29], safety_good);
    end
    tick(1);
    mv_en = 1'b0;
    tick(1);
    @(negedge clk);
    checks++;
    if (reg_rdata[28] !== 1'b1) begin
      errors++; $display("FAIL np_settle: ch1_settle=%b want 1", reg_rdata[28]);
    end
    tick(2);
    ioexp_cfg_present = 1'b0;
    tick(1);
    @(negedge clk);
    checks++;
    if (mv_good !== 1'b0 || reg_rdata[28] !== 1'b0) begin
      errors++; $display("FAIL np_hold: mv_good=%b settle=%b want 0/0", mv_good, reg_rdata[28]);
    end
    tick(26);
    @(negedge clk);
    checks++;
    if (reg_rdata[30:29] !== 2'b01 || fb_fault !== 1'b1 || mv_good !== 1'b0) begin
      errors++; $display("FAIL np_no_timeout: sticky=%b fault=%b mv_good=%b want 01/1/0",
                         reg_rdata[30:29], fb_fault, mv_good);
    end
    P98 = 2'b00;
    mv_en = 1'b0;
    safety_en = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (reg_rdata[31:20] !== 12'h000 || reg_rdata[15:0] !== 16'h0000) begin
      errors++; $display("FAIL np_reset: rdata=%h want 000xxxxx with zero counts", reg_rdata);
    end
    checks++;
    if (fb_fault !== 1'b0) begin
      errors++; $display("FAIL np_reset_fault: fb_fault=%b want 0", fb_fault);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_good_settle();
    test_timeout();
    test_unexpected_drop();
    test_clear();
    test_not_present();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
